// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU definitions: op encoding, the op sweep used by the
//            BIST, the Galois LFSR/MISR polynomial and its step function,
//            and a behavioural ALU reference.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_t;

  localparam int NUM_OPS = 10;

  localparam alu_op_t ALU_BIST_OPS [NUM_OPS] = '{
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU
  };

  // x^32 + x^22 + x^2 + x + 1, Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] alu_ref(input alu_op_t op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $signed(a) >>> b[4:0];
      OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'b0, a < b};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist_if
// Purpose  : Operand/op bus between the BIST initiator and the ALU.
//   master : drives alu_op, in_a, in_b; receives result, zero (BIST side)
//   slave  : receives alu_op, in_a, in_b; drives result, zero (ALU side)
// Revision : 1.0 - initial release
// ============================================================================
interface alu_bist_if;
  import alu_pkg::*;

  alu_op_t     alu_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] result;
  logic        zero;

  modport master (output alu_op, in_a, in_b, input  result, zero);
  modport slave  (input  alu_op, in_a, in_b, output result, zero);
endinterface
`default_nettype wire

// File: rtl/alu_bist_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist_lfsr
// Purpose  : 32-bit Galois LFSR operand generator with load/step/hold.
// Ports    : clk, rst     - clock, synchronous active-high reset (state -> 0)
//            load_i       - load seed_i (priority over step_i)
//            step_i       - advance one LFSR step
//            seed_i       - seed value
//            state_o      - current LFSR value
// Revision : 1.0 - initial release
// ============================================================================
module alu_bist_lfsr
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] seed_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 32'h0;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (step_i) begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist
// Purpose  : ALU self-test initiator. Sweeps every ALU op over NUM_VECTORS
//            pseudo-random operand pairs and compacts result/zero into a
//            32-bit MISR signature compared against GOLDEN_SIG.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            start      - begin a run (honoured in IDLE or DONE only)
//            alu        - operand/op bus (master side)
//            busy       - high during RUN
//            done       - high in DONE
//            pass       - done && signature matches (and no ref mismatch)
//            signature  - current MISR value
//            mismatch_cnt - saturating reference-mismatch count
//                           (only with ALU_BIST_REF_CHECK_EN)
// Options  : `define ALU_BIST_REF_CHECK_EN to add the behavioural reference
//            comparison and the mismatch_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_bist
  import alu_pkg::*;
#(
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED_A      = 32'h0000_0001,
  parameter logic [31:0] SEED_B      = 32'hACE1_2468,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  alu_bist_if.master        alu,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [31:0]       signature
`ifdef ALU_BIST_REF_CHECK_EN
  ,
  output logic [15:0]       mismatch_cnt
`endif
);

  localparam int VW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

  if (NUM_VECTORS < 1) begin : g_chk_nv
    $error("alu_bist: NUM_VECTORS must be >= 1");
  end
  if (SEED_A == 32'h0) begin : g_chk_seed_a
    $error("alu_bist: SEED_A must be nonzero");
  end
  if (SEED_B == 32'h0) begin : g_chk_seed_b
    $error("alu_bist: SEED_B must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic          busy_q;
  logic          done_q;
  logic [31:0]   misr_q;
  logic [31:0]   misr_d;
  logic [3:0]    op_idx_q;
  logic [VW-1:0] vec_cnt_q;
  logic [31:0]   lfsr_a;
  logic [31:0]   lfsr_b;
  logic          run;
  logic          load;
  logic          op_last;
  logic          vec_last;
  alu_op_t       cur_op;

  assign run      = (state_q == S_RUN);
  assign load     = (state_q != S_RUN) && start;
  assign op_last  = (op_idx_q == 4'(NUM_OPS - 1));
  assign vec_last = (vec_cnt_q == VW'(NUM_VECTORS - 1));
  assign cur_op   = ALU_BIST_OPS[op_idx_q];

  // Both operand generators advance once per completed op sweep.
  alu_bist_lfsr u_lfsr_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .step_i  (run && op_last),
    .seed_i  (SEED_A),
    .state_o (lfsr_a)
  );

  alu_bist_lfsr u_lfsr_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .step_i  (run && op_last),
    .seed_i  (SEED_B),
    .state_o (lfsr_b)
  );

  // Bus is quiet (ADD of zeros) outside RUN so the source mux sees no activity.
  always_comb begin
    alu.alu_op = OP_ADD;
    alu.in_a   = 32'h0;
    alu.in_b   = 32'h0;
    if (run) begin
      alu.alu_op = cur_op;
      alu.in_a   = lfsr_a;
      alu.in_b   = lfsr_b;
    end
  end

  // zero flag folds into the MSB so it is compacted alongside the result.
  assign misr_d = lfsr_step(misr_q) ^ (alu.result ^ {alu.zero, 31'b0});

`ifdef ALU_BIST_REF_CHECK_EN
  logic [15:0] mm_cnt_q;
  logic [31:0] ref_res;
  logic        mismatch;

  assign ref_res  = alu_ref(cur_op, lfsr_a, lfsr_b);
  assign mismatch = (alu.result != ref_res) || (alu.zero != (ref_res == 32'h0));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      mm_cnt_q <= 16'h0;
    end else if (run && mismatch && (mm_cnt_q != 16'hFFFF)) begin
      mm_cnt_q <= mm_cnt_q + 16'h1;
    end
  end

  assign mismatch_cnt = mm_cnt_q;
  assign pass = done_q && (misr_q == GOLDEN_SIG) && (mm_cnt_q == 16'h0);
`else
  assign pass = done_q && (misr_q == GOLDEN_SIG);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      misr_q    <= 32'h0;
      op_idx_q  <= 4'h0;
      vec_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            misr_q    <= 32'h0;
            op_idx_q  <= 4'h0;
            vec_cnt_q <= '0;
          end
        end
        S_RUN: begin
          misr_q <= misr_d;
          if (op_last) begin
            op_idx_q  <= 4'h0;
            vec_cnt_q <= vec_cnt_q + VW'(1);
            if (vec_last) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            op_idx_q <= op_idx_q + 4'h1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = misr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_bist
// Purpose  : Self-checking bench for alu_bist. Supplies a behavioural ALU
//            (with an optional stuck-at-0 result mask), a signature model
//            computed straight from the op/LFSR/MISR rules, a table of
//            expected bus values and hand-written reset/restart sequences.
// Options  : honours ALU_BIST_REF_CHECK_EN (connects/checks mismatch_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_bist;

  localparam int NV = 4;
  localparam logic [31:0] SA = 32'h0000_0001;
  localparam logic [31:0] SB = 32'hACE1_2468;

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] h;
    h = s >> 1;
    if (s[0]) h = h ^ 32'h8020_0003;
    return h;
  endfunction

  function automatic logic [31:0] m_alu(input int op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: return 32'($signed(a) >>> sh);
      8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_sig(input int nv, input logic [31:0] stk);
    logic [31:0] a, b, m, r;
    a = SA; b = SB; m = 32'h0;
    for (int v = 0; v < nv; v++) begin
      for (int op = 0; op < 10; op++) begin
        r = m_alu(op, a, b) & ~stk;
        m = m_step(m) ^ r ^ ((r == 32'h0) ? 32'h8000_0000 : 32'h0);
      end
      a = m_step(a);
      b = m_step(b);
    end
    return m;
  endfunction

  function automatic int model_mm(input int nv, input logic [31:0] stk);
    logic [31:0] a, b;
    int n;
    a = SA; b = SB; n = 0;
    for (int v = 0; v < nv; v++) begin
      for (int op = 0; op < 10; op++)
        if ((m_alu(op, a, b) & stk) != 32'h0) n++;
      a = m_step(a);
      b = m_step(b);
    end
    return n;
  endfunction

  localparam logic [31:0] GOLD = model_sig(NV, 32'h0);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass;
  logic [31:0] signature;
  logic [31:0] stuck;
  logic [3:0]  op_w;
`ifdef ALU_BIST_REF_CHECK_EN
  logic [15:0] mismatch_cnt;
`endif

  alu_bist_if bus ();

  alu_bist #(
    .NUM_VECTORS (NV),
    .SEED_A      (SA),
    .SEED_B      (SB),
    .GOLDEN_SIG  (GOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu       (bus.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
`ifdef ALU_BIST_REF_CHECK_EN
    ,
    .mismatch_cnt (mismatch_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign op_w = bus.alu_op;

  // Behavioural ALU with a stuck-at-0 fault mask on the result.
  always_comb begin
    bus.result = m_alu(int'(op_w), bus.in_a, bus.in_b) & ~stuck;
    bus.zero   = (bus.result == 32'h0);
  end

  typedef struct {
    int          cyc;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t tbl [6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_run(input logic [31:0] stk, input int restart_at,
                        input bit use_tbl, output logic [31:0] sig_out);
    int          cyc;
    bit          done_seen;
    logic [31:0] exp;
    stuck = stk;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    done_seen = 1'b0;
    while (busy && cyc < NV * 10 + 20) begin
      if (done) done_seen = 1'b1;
      if (use_tbl)
        for (int i = 0; i < 6; i++)
          if (tbl[i].cyc == cyc) begin
            chk($sformatf("op@%0d", cyc), 32'(op_w), 32'(tbl[i].op));
            chk($sformatf("in_a@%0d", cyc), bus.in_a, tbl[i].a);
            chk($sformatf("in_b@%0d", cyc), bus.in_b, tbl[i].b);
          end
      start = (cyc == restart_at);
      tick();
      cyc++;
    end
    start = 1'b0;
    exp = model_sig(NV, stk);
    chk("run_len", 32'(cyc), 32'(NV * 10));
    chk("done_low_in_run", 32'(done_seen), 32'd0);
    chk("done_rise", 32'(done), 32'd1);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    chk("signature", signature, exp);
    chk("pass", 32'(pass), 32'(exp == GOLD));
`ifdef ALU_BIST_REF_CHECK_EN
    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(model_mm(NV, stk)));
`endif
    sig_out = signature;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sig1, sig2, sig3;
    logic [31:0] stk;

    tbl[0] = '{0,  4'd0, 32'h0000_0001, 32'hACE1_2468};
    tbl[1] = '{1,  4'd1, 32'h0000_0001, 32'hACE1_2468};
    tbl[2] = '{9,  4'd9, 32'h0000_0001, 32'hACE1_2468};
    tbl[3] = '{10, 4'd0, 32'h8020_0003, 32'h5670_9234};
    tbl[4] = '{15, 4'd5, 32'h8020_0003, 32'h5670_9234};
    tbl[5] = '{20, 4'd0, 32'hC030_0002, 32'h2B38_491A};

    stuck = 32'h0;
    start = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_sig", signature, 32'h0);
    chk("rst_op", 32'(op_w), 32'd0);
    chk("rst_in_a", bus.in_a, 32'h0);
    chk("rst_in_b", bus.in_b, 32'h0);

    // Clean run from IDLE with bus-value table checks.
    do_run(32'h0, -1, 1'b1, sig1);

    // Signature and done hold through DONE, bus quiet.
    repeat (3) tick();
    chk("hold_sig", signature, sig1);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_in_a", bus.in_a, 32'h0);

    // Rerun from DONE with start re-pulsed on RUN cycle 3.
    do_run(32'h0, 3, 1'b0, sig2);
    chk("rerun_same_sig", sig2, sig1);

    // Stuck-at-0 on result bit 0.
    do_run(32'h1, -1, 1'b0, sig3);

    // Randomised fault masks and idle gaps.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 5)) tick();
      stk = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      do_run(stk, -1, 1'b0, sig3);
    end

    // Reset on RUN cycle 5.
    stuck = 32'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sig", signature, 32'h0);
    chk("midrst_in_a", bus.in_a, 32'h0);
    chk("midrst_op", 32'(op_w), 32'd0);
    tick();
    chk("midrst_idle", 32'(busy | done), 32'd0);

    // Clean run from IDLE after the aborted one.
    do_run(32'h0, -1, 1'b0, sig3);
    chk("post_rst_sig", sig3, sig1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
